// File: rtl/uart_loader.sv
// Serial program loader: receives a framed image over UART, writes 32-bit words to
// instruction memory, and holds the CPU in reset until the whole image has landed.
module uart_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          ADDR_W       = 10,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              frame_err
);

  localparam int                TMR_W     = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0]  FULL_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0]  HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]       DEPTH     = 17'(1 << ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    LD_WAIT_SYNC, LD_LEN_LO, LD_LEN_HI, LD_WORD, LD_WR, LD_DONE
  } ld_state_t;
  // Both FSM states live in one packed struct so a checker can bind to a single signal.
  typedef struct packed {
    rx_state_t rx;
    ld_state_t ld;
  } fsm_state_t;

  fsm_state_t        r_fsm;
  rx_state_t         w_rx_next;
  ld_state_t         w_ld_next;

  logic              r_rx_s1, r_rx_s2;
  logic [TMR_W-1:0]  r_tmr;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_byte_valid;
  logic              r_frame_err;

  logic [15:0]       r_len;
  logic [15:0]       r_word_idx;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_word;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_load_done;
  logic              r_cpu_hold;

  logic              w_tick_full, w_tick_half, w_abort, w_in_range;
  logic [15:0]       w_word_idx_inc;

  assign w_tick_full    = (r_tmr == FULL_LAST);
  assign w_tick_half    = (r_tmr == HALF_LAST);
  assign w_abort        = r_frame_err && (r_fsm.ld != LD_DONE);
  assign w_in_range     = ({1'b0, r_word_idx} < DEPTH);
  assign w_word_idx_inc = r_word_idx + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm.rx <= RX_IDLE;
      r_fsm.ld <= LD_WAIT_SYNC;
    end else begin
      r_fsm.rx <= w_rx_next;
      r_fsm.ld <= w_ld_next;
    end
  end

  always_comb begin
    w_rx_next = r_fsm.rx;
    case (r_fsm.rx)
      RX_IDLE:  if (!r_rx_s2) w_rx_next = RX_START;
      RX_START: if (w_tick_half) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick_full && r_bit_cnt == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_tick_full) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // r_byte_valid is a one-cycle strobe with r_shift holding the byte; there is no
  // back-pressure, the loader must consume it in the cycle it is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_tmr        <= '0;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_s1      <= rx;
      r_rx_s2      <= r_rx_s1;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_fsm.rx)
        RX_IDLE: r_tmr <= '0;
        RX_START: begin
          r_bit_cnt <= 3'd0;
          r_tmr     <= w_tick_half ? '0 : r_tmr + 1'b1;
        end
        RX_DATA: begin
          if (w_tick_full) begin
            r_tmr     <= '0;
            r_shift   <= {r_rx_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_tick_full) begin
            r_tmr <= '0;
            if (r_rx_s2) r_byte_valid <= 1'b1;
            else         r_frame_err  <= 1'b1;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: r_tmr <= '0;
      endcase
    end
  end

  always_comb begin
    w_ld_next = r_fsm.ld;
    case (r_fsm.ld)
      LD_WAIT_SYNC: if (r_byte_valid && r_shift == SYNC_BYTE) w_ld_next = LD_LEN_LO;
      LD_LEN_LO:    if (r_byte_valid) w_ld_next = LD_LEN_HI;
      LD_LEN_HI:    if (r_byte_valid)
                      w_ld_next = ({r_shift, r_len[7:0]} == 16'd0) ? LD_DONE : LD_WORD;
      LD_WORD:      if (r_byte_valid && r_byte_idx == 2'd3) w_ld_next = LD_WR;
      LD_WR:        w_ld_next = (w_word_idx_inc == r_len) ? LD_DONE : LD_WORD;
      LD_DONE:      w_ld_next = LD_DONE;
      default:      w_ld_next = LD_WAIT_SYNC;
    endcase
    if (w_abort) w_ld_next = LD_WAIT_SYNC;
  end

  // The write strobe is registered on the 4th byte, so it is high exactly while in WR.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len       <= 16'd0;
      r_word_idx  <= 16'd0;
      r_byte_idx  <= 2'd0;
      r_word      <= 24'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_load_done <= 1'b0;
      r_cpu_hold  <= 1'b1;
    end else begin
      r_mem_we    <= 1'b0;
      r_load_done <= (w_ld_next == LD_DONE);
      r_cpu_hold  <= (w_ld_next != LD_DONE);
      if (w_abort) begin
        r_len      <= 16'd0;
        r_word_idx <= 16'd0;
        r_byte_idx <= 2'd0;
      end else begin
        case (r_fsm.ld)
          LD_LEN_LO: if (r_byte_valid) r_len[7:0] <= r_shift;
          LD_LEN_HI: if (r_byte_valid) begin
            r_len[15:8] <= r_shift;
            r_word_idx  <= 16'd0;
            r_byte_idx  <= 2'd0;
          end
          LD_WORD: if (r_byte_valid) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word[7:0]   <= r_shift;
              2'd1: r_word[15:8]  <= r_shift;
              2'd2: r_word[23:16] <= r_shift;
              default: begin
                r_mem_we <= w_in_range;
                if (w_in_range) begin
                  r_mem_addr  <= r_word_idx[ADDR_W-1:0];
                  r_mem_wdata <= {r_shift, r_word};
                end
              end
            endcase
          end
          LD_WR: begin
            r_word_idx <= w_word_idx_inc;
            r_byte_idx <= 2'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign load_done = r_load_done;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: UART byte driver, stream-parsing reference model and a
// write scoreboard checked on the falling clock edge.
module tb_uart_loader;

  localparam int         CPB  = 4;
  localparam int         AW   = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          frame_err;

  uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .frame_err(frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // {last_word, addr, data}
  logic [AW+32:0] exp_q[$];
  logic [7:0]     m_buf[$];
  logic [8:0]     tx_q[$];     // bit 8 set = send with a bad stop bit
  bit             m_done;
  int             m_fe;
  int             fe_seen;
  bit             chk_done_next;
  logic [AW+32:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: keeps the good bytes received since the last sync/abort and
  // parses them as "SYNC, len_lo, len_hi, words..." after every new byte.
  task automatic model_byte(input logic [7:0] b, input bit good);
    int          n;
    int          k;
    int          len;
    logic [31:0] w;
    if (!good) begin
      m_fe++;
      if (!m_done) m_buf.delete();
    end else if (!m_done && (m_buf.size() != 0 || b == SYNC)) begin
      m_buf.push_back(b);
      n = m_buf.size();
      if (n >= 3) begin
        len = {m_buf[2], m_buf[1]};
        if (n == 3) begin
          if (len == 0) m_done = 1'b1;
        end else if ((n - 3) % 4 == 0) begin
          k = (n - 3) / 4 - 1;
          w = {m_buf[n-1], m_buf[n-2], m_buf[n-3], m_buf[n-4]};
          if (k < (1 << AW)) exp_q.push_back({(k + 1 == len), AW'(k), w});
          if (k + 1 == len) m_done = 1'b1;
        end
      end
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit good);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good;
    repeat (CPB) @(negedge clk);
    model_byte(b, good);
    rx = 1'b1;
    repeat ($urandom_range(1, 6)) @(negedge clk);
  endtask

  task automatic send_q();
    logic [8:0] e;
    while (tx_q.size() != 0) begin
      e = tx_q.pop_front();
      send_byte(e[7:0], !e[8]);
    end
  endtask

  task automatic push_hdr(input logic [15:0] len);
    tx_q.push_back({1'b0, SYNC});
    tx_q.push_back({1'b0, len[7:0]});
    tx_q.push_back({1'b0, len[15:8]});
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_q.push_back({1'b0, w[8*i +: 8]});
  endtask

  task automatic do_reset(input bit check_vals);
    rx    = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    if (check_vals) begin
      check("rst_mem_we",    32'(mem_we),    32'd0);
      check("rst_mem_addr",  32'(mem_addr),  32'd0);
      check("rst_mem_wdata", mem_wdata,      32'd0);
      check("rst_cpu_hold",  32'(cpu_hold),  32'd1);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
    end
    m_buf.delete();
    exp_q.delete();
    tx_q.delete();
    m_done        = 1'b0;
    m_fe          = 0;
    fe_seen       = 0;
    chk_done_next = 1'b0;
    reset = 1'b0;
  endtask

  task automatic end_test(input string name);
    repeat (30) @(negedge clk);
    check({name, "_done"},    32'(load_done),     32'(m_done));
    check({name, "_hold"},    32'(cpu_hold),      32'(!m_done));
    check({name, "_wr_left"}, 32'(exp_q.size()),  32'd0);
    check({name, "_fe_cnt"},  32'(fe_seen),       32'(m_fe));
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset) begin
      if (chk_done_next) begin
        check("done_after_last_wr", 32'(load_done), 32'd1);
        check("hold_after_last_wr", 32'(cpu_hold),  32'd0);
        chk_done_next = 1'b0;
      end
      if (frame_err) fe_seen++;
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 32'(mem_we), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(mon_e[AW+31:32]));
          check("wr_data", mem_wdata, mon_e[31:0]);
          check("wr_before_done", 32'(load_done), 32'd0);
          chk_done_next = mon_e[AW+32];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          nw;

    // idle line after reset
    do_reset(1'b1);
    repeat (200) @(negedge clk);
    end_test("idle");

    // two-word image
    do_reset(1'b0);
    push_hdr(16'd2);
    push_word(32'h0000_0013);
    push_word(32'h0010_0093);
    send_q();
    end_test("two_words");

    // leading garbage, then zero-length image
    do_reset(1'b0);
    tx_q.push_back(9'h000);
    tx_q.push_back(9'h07F);
    push_hdr(16'd0);
    send_q();
    end_test("len_zero");

    // framing error aborts, then a clean resend
    do_reset(1'b0);
    push_hdr(16'd1);
    tx_q.push_back(9'h011);
    tx_q.push_back(9'h122);
    push_hdr(16'd1);
    push_word(32'h4433_2211);
    send_q();
    end_test("frame_err");

    // short low glitch on the idle line
    do_reset(1'b0);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    end_test("glitch");

    // reset in the middle of a word, then a full load
    do_reset(1'b0);
    push_hdr(16'd2);
    tx_q.push_back({1'b0, 8'($urandom_range(0, 255))});
    tx_q.push_back({1'b0, 8'($urandom_range(0, 255))});
    send_q();
    do_reset(1'b1);
    push_hdr(16'd2);
    push_word($urandom);
    push_word($urandom);
    send_q();
    end_test("reset_mid_word");

    // image longer than memory, then traffic after done
    do_reset(1'b0);
    push_hdr(16'd17);
    for (int i = 0; i < 17; i++) push_word($urandom);
    push_hdr(16'd1);
    push_word($urandom);
    tx_q.push_back({1'b1, 8'h5A});
    send_q();
    end_test("overflow");

    // random images with occasional garbage and framing errors
    for (int t = 0; t < 4; t++) begin
      do_reset(1'b0);
      repeat ($urandom_range(0, 2)) begin
        w = $urandom_range(0, 255);
        if (w[7:0] == SYNC) w = 32'd0;
        tx_q.push_back({1'b0, w[7:0]});
      end
      nw = $urandom_range(1, 5);
      push_hdr(16'(nw));
      for (int i = 0; i < nw; i++) push_word($urandom);
      if ($urandom_range(0, 1) == 1) begin
        tx_q[$urandom_range(0, tx_q.size() - 1)][8] = 1'b1;
        push_hdr(16'(nw));
        for (int i = 0; i < nw; i++) push_word($urandom);
      end
      send_q();
      end_test("random");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
